// File: rtl/instr_loader_if.sv
// instr_loader_if: byte stream handshake plus instruction-memory write port
//   InByte/InValid/InReady          : byte stream, master drives bytes, slave accepts
//   InstrWrEn/InstrAddr/InstrData   : one-cycle write strobe, address and 9-bit word from the slave
interface instr_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        InByte;
   logic              InValid;
   logic              InReady;
   logic              InstrWrEn;
   logic [ADDR_W-1:0] InstrAddr;
   logic [8:0]        InstrData;
   modport master (output InByte, InValid, input InReady, InstrWrEn, InstrAddr, InstrData);
   modport slave  (input InByte, InValid, output InReady, InstrWrEn, InstrAddr, InstrData);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: boot-time loader packing a byte stream into 9-bit words for instruction memory
//   Clk/Reset  : clock, asynchronous active-high reset
//   Start      : begin a load session (honoured in IDLE, DONE, ERR)
//   bus        : byte stream in, instruction-memory write port out
//   CoreHold   : core held off until a load completes
//   Done/Error : session completed / aborted (levels)
//   LoadCount  : words written this session
module instr_loader #(
   parameter int ADDR_W = 10
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   instr_loader_if.slave   bus,
   output logic            CoreHold,
   output logic            Done,
   output logic            Error,
   output logic [ADDR_W:0] LoadCount
);
   typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, FLUSH, DONE, ERR} state_t;
   localparam logic [16:0] CAP = 17'(1) << ADDR_W;
   state_t            state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [7:0]        lo_q, lo_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [8:0]        data_q, data_d;
   logic              acc, hi_ok, last;
   logic [15:0]       n_full;
   assign acc    = bus.InValid & bus.InReady;
   assign hi_ok  = bus.InByte[7:1] == 7'd0;
   assign n_full = {bus.InByte, n_q[7:0]};
   // cnt_q doubles as the write index; it matches LoadCount at every point
   assign last   = 17'(cnt_q) + 17'd1 == {1'b0, n_q};
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: state_d = Start ? CNT_LO : state_q;
         CNT_LO:          state_d = acc ? CNT_HI : state_q;
         CNT_HI:          state_d = !acc ? state_q : n_full == 16'd0 ? FLUSH : {1'b0, n_full} > CAP ? ERR : INS_LO;
         INS_LO:          state_d = acc ? INS_HI : state_q;
         INS_HI:          state_d = !acc ? state_q : !hi_ok ? ERR : last ? FLUSH : INS_LO;
         FLUSH:           state_d = DONE;
         default:         state_d = state_q;
      endcase
   end
   always_comb begin
      bus.InReady = state_q inside {CNT_LO, CNT_HI, INS_LO, INS_HI};
      Done        = state_q == DONE;
      Error       = state_q == ERR;
      CoreHold    = state_q != DONE;
   end
   always_comb begin
      n_d    = n_q;
      lo_d   = lo_q;
      cnt_d  = cnt_q;
      wr_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (Start && state_q inside {IDLE, DONE, ERR}) cnt_d = '0;
      if (acc && state_q == CNT_LO) n_d[7:0] = bus.InByte;
      if (acc && state_q == CNT_HI) n_d[15:8] = bus.InByte;
      if (acc && state_q == INS_LO) lo_d = bus.InByte;
      if (acc && state_q == INS_HI && hi_ok) begin
         wr_d   = 1'b1;
         addr_d = cnt_q[ADDR_W-1:0];
         data_d = {bus.InByte[0], lo_q};
         cnt_d  = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         n_q    <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         n_q    <= n_d;
         lo_q   <= lo_d;
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end
   assign bus.InstrWrEn = wr_q;
   assign bus.InstrAddr = addr_q;
   assign bus.InstrData = data_q;
   assign LoadCount     = cnt_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and random load sessions checked against a stream-level model
module tb_instr_loader;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, sel = 1'b0, in_valid = 1'b0;
   logic [7:0] in_byte = 8'd0;
   always #5 clk = ~clk;
   instr_loader_if #(.ADDR_W(10)) if10 ();
   instr_loader_if #(.ADDR_W(3))  if3 ();
   logic hold10, done10, err10, hold3, done3, err3;
   logic [10:0] cnt10;
   logic [3:0]  cnt3;
   assign if10.InByte  = in_byte;
   assign if10.InValid = in_valid & ~sel;
   assign if3.InByte   = in_byte;
   assign if3.InValid  = in_valid & sel;
   instr_loader #(.ADDR_W(10)) dut10 (.Clk(clk), .Reset(rst), .Start(start & ~sel), .bus(if10),
      .CoreHold(hold10), .Done(done10), .Error(err10), .LoadCount(cnt10));
   instr_loader #(.ADDR_W(3)) dut3 (.Clk(clk), .Reset(rst), .Start(start & sel), .bus(if3),
      .CoreHold(hold3), .Done(done3), .Error(err3), .LoadCount(cnt3));
   logic o_ready, o_wr, o_done, o_err, o_hold;
   logic [9:0]  o_addr;
   logic [8:0]  o_data;
   logic [10:0] o_cnt;
   assign o_ready = sel ? if3.InReady : if10.InReady;
   assign o_wr    = sel ? if3.InstrWrEn : if10.InstrWrEn;
   assign o_addr  = sel ? 10'(if3.InstrAddr) : if10.InstrAddr;
   assign o_data  = sel ? if3.InstrData : if10.InstrData;
   assign o_done  = sel ? done3 : done10;
   assign o_err   = sel ? err3 : err10;
   assign o_hold  = sel ? hold3 : hold10;
   assign o_cnt   = sel ? 11'(cnt3) : cnt10;
   int checks = 0, failures = 0;
   int cyc = 0, i_used = 0, last_acc = -1, last_wr = -1, done_cyc = -1, rdy_bad = 0, exp_used = 0;
   bit done_seen = 0, exp_err = 0;
   logic [7:0]  bytes[$];
   logic [18:0] wq[$], exp_wq[$];
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (o_wr) begin
         wq.push_back({o_addr, o_data});
         last_wr = cyc;
      end
      if ((o_done || o_err) && o_ready) rdy_bad++;
      if (o_done && !done_seen) begin
         done_seen = 1;
         done_cyc = cyc;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // stream-level reference: what a well-behaved loader must write and how it must end
   task automatic model(input int aw);
      int n;
      exp_wq.delete();
      exp_err = 0;
      exp_used = 2;
      n = int'(bytes[0]) | (int'(bytes[1]) << 8);
      if (n > (1 << aw)) begin
         exp_err = 1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         exp_used += 2;
         if (bytes[2*k+3][7:1] != 7'd0) begin
            exp_err = 1;
            return;
         end
         exp_wq.push_back({10'(k), bytes[2*k+3][0], bytes[2*k+2]});
      end
   endtask
   task automatic begin_session();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wq.delete();
      done_seen = 0;
      rdy_bad = 0;
      last_acc = -1;
      last_wr = -1;
   endtask
   task automatic drive(input int lim, input int mode);
      int t = 0;
      bit ph = 1;
      i_used = 0;
      while (i_used < lim && !(o_done || o_err) && t < 3000) begin
         in_byte  = bytes[i_used];
         in_valid = mode == 0 ? 1'b1 : mode == 1 ? ph : 1'($urandom_range(0, 1));
         start    = $urandom_range(0, 7) == 0;
         ph = !ph;
         @(negedge clk);
         if (in_valid && o_ready) begin
            i_used++;
            last_acc = cyc + 1;
         end
         @(posedge clk);
         #1 t++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      check("timeout", {31'd0, t < 3000}, 1);
   endtask
   task automatic check_session(input string tag);
      check({tag, "_used"}, i_used, exp_used);
      check({tag, "_nwr"}, wq.size(), exp_wq.size());
      for (int k = 0; k < wq.size() && k < exp_wq.size(); k++)
         check($sformatf("%s_wr%0d", tag, k), wq[k], exp_wq[k]);
      check({tag, "_done"}, o_done, !exp_err);
      check({tag, "_err"}, o_err, exp_err);
      check({tag, "_hold"}, o_hold, exp_err);
      check({tag, "_cnt"}, o_cnt, exp_wq.size());
      check({tag, "_rdy"}, rdy_bad, 0);
      if (!exp_err) check({tag, "_lat"}, done_cyc - last_acc, 1);
      if (!exp_err && exp_wq.size() > 0) check({tag, "_wlat"}, last_wr, last_acc);
   endtask
   task automatic run(input int aw, input int mode, input string tag);
      model(aw);
      begin_session();
      drive(bytes.size(), mode);
      repeat (3) @(posedge clk);
      #1;
      check_session(tag);
   endtask
   task automatic check_reset(input string tag);
      check({tag, "_ready"}, o_ready, 0);
      check({tag, "_wr"}, o_wr, 0);
      check({tag, "_addr"}, o_addr, 0);
      check({tag, "_data"}, o_data, 0);
      check({tag, "_hold"}, o_hold, 1);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_err"}, o_err, 0);
      check({tag, "_cnt"}, o_cnt, 0);
   endtask
   initial begin
      #2 rst = 1'b1;
      #1 check_reset("rst");
      @(negedge clk);
      rst = 1'b0;
      bytes = '{8'h02, 8'h00, 8'h05, 8'h00, 8'hFF, 8'h01};
      run(10, 0, "full");
      check("full_w0", wq[0], {10'd0, 9'h005});
      check("full_w1", wq[1], {10'd1, 9'h1FF});
      run(10, 1, "toggle");
      bytes = '{8'h01, 8'h00, 8'h12, 8'h02};
      run(10, 0, "badhi");
      bytes = '{8'h01, 8'h00, 8'h34, 8'h01};
      run(10, 2, "recover");
      bytes = '{8'h00, 8'h00};
      run(10, 0, "zero");
      bytes = '{8'h01, 8'h04, 8'h00, 8'h00};
      run(10, 0, "over");
      bytes = '{8'h00, 8'h04};
      for (int k = 0; k < 1024; k++) begin
         bytes.push_back(8'(k));
         bytes.push_back({7'd0, 1'(k >> 8)});
      end
      run(10, 0, "max");
      sel = 1'b1;
      bytes = '{8'h08, 8'h00};
      for (int k = 0; k < 8; k++) begin
         bytes.push_back(8'(k));
         bytes.push_back(8'h01);
      end
      run(3, 0, "a3");
      check("a3_last", wq[7], {10'd7, 9'h107});
      bytes = '{8'h09, 8'h00, 8'h00, 8'h01};
      run(3, 1, "a3_over");
      sel = 1'b0;
      bytes = '{8'h05, 8'h00};
      for (int k = 0; k < 5; k++) begin
         bytes.push_back(8'($urandom));
         bytes.push_back({7'd0, 1'($urandom)});
      end
      model(10);
      begin_session();
      drive(8, 0);
      #5;
      check("mid_nwr", wq.size(), 3);
      check("mid_w2", wq[2], exp_wq[2]);
      rst = 1'b1;
      #1 check_reset("mid");
      @(negedge clk);
      rst = 1'b0;
      bytes = '{8'h03, 8'h00, 8'hA5, 8'h00, 8'h5A, 8'h01, 8'h77, 8'h00};
      run(10, 2, "fresh");
      check("fresh_w0", wq[0], {10'd0, 9'h0A5});
      for (int r = 0; r < 20; r++) begin
         int n;
         n = $urandom_range(1, 6);
         bytes.delete();
         if ($urandom_range(0, 5) == 0) begin
            bytes.push_back(8'h01);
            bytes.push_back(8'h04);
         end else begin
            bytes.push_back(8'(n));
            bytes.push_back(8'h00);
            for (int k = 0; k < n; k++) begin
               bytes.push_back(8'($urandom));
               bytes.push_back($urandom_range(0, 9) == 0 ? {7'($urandom_range(1, 127)), 1'($urandom)} : {7'd0, 1'($urandom)});
            end
         end
         run(10, 2, $sformatf("rnd%0d", r));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
